regid_pipe: RTL and testbench

//  - Parametrised elastic delay line; the generalised successor of our fixed two-stage data register.
//  - Moves WORD_SIZE-bit words through DEPTH register stages with a valid/ready handshake.
//  - Empty stages collapse out as bubbles, and a synchronous flush drops everything in flight.
//  - Used between datapath blocks (mux, FSM, bus inverter) wherever retiming must tolerate backpressure.

---
 rtl/regid_pipe.sv | 103 ++++++++++
 tb/tb_regid_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regid_pipe.sv
// regid_pipe: elastic delay line of DEPTH register stages carrying WORD_SIZE-bit
// words under a valid/ready handshake. Empty stages collapse as bubbles, and a
// synchronous flush discards every word in flight.
// Optional feature macro: REGID_PIPE_OCC_EN adds a registered occupancy port.
module regid_pipe #(
   parameter int unsigned WORD_SIZE = 4,
   parameter int unsigned DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] data_in,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [WORD_SIZE-1:0] data_out,
   input  logic                 out_ready
`ifdef REGID_PIPE_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

   logic [DEPTH-1:0]                v;
   logic [DEPTH-1:0]                v_nxt;
   logic [DEPTH-1:0][WORD_SIZE-1:0] d;
   logic [DEPTH-1:0][WORD_SIZE-1:0] d_nxt;
   logic [DEPTH-1:0]                adv;
   logic                            carry;

   // Advance enables ripple from the output stage back towards the input.
   always_comb begin
      adv   = '0;
      carry = out_ready;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         adv[DEPTH-1-k] = ~v[DEPTH-1-k] | carry;
         carry          = adv[DEPTH-1-k];
      end
   end

   assign in_ready  = adv[0] & ~flush;
   assign out_valid = v[DEPTH-1];
   assign data_out  = d[DEPTH-1];

   // Next stage contents: flush clears valids only; otherwise advancing stages
   // take their source valid and load data only from a valid source.
   always_comb begin
      v_nxt = v;
      d_nxt = d;
      if (flush) begin
         v_nxt = '0;
      end else begin
         if (adv[0]) begin
            v_nxt[0] = in_valid;
            if (in_valid) begin
               d_nxt[0] = data_in;
            end
         end
         for (int unsigned k = 1; k < DEPTH; k++) begin
            if (adv[k]) begin
               v_nxt[k] = v[k-1];
               if (v[k-1]) begin
                  d_nxt[k] = d[k-1];
               end
            end
         end
      end
   end

   // Stage registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v <= '0;
         d <= '0;
      end else begin
         v <= v_nxt;
         d <= d_nxt;
      end
   end

`ifdef REGID_PIPE_OCC_EN
   localparam int unsigned OCC_W = $clog2(DEPTH+1);
   logic [OCC_W-1:0] occ_nxt;

   // Popcount of the next valid vector; bounded by DEPTH by construction.
   always_comb begin
      occ_nxt = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         occ_nxt = occ_nxt + OCC_W'(v_nxt[k]);
      end
   end

   // Registered occupancy, tracking the stage valids after each edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occupancy <= '0;
      end else begin
         occupancy <= occ_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_regid_pipe.sv
// tb_regid_pipe: two instances (DEPTH=2 and DEPTH=4) driven independently and
// compared every cycle against a word-position reference model.
module tb_regid_pipe;

   localparam int W  = 4;
   localparam int D0 = 2;
   localparam int D1 = 4;

   typedef struct {
      logic [W-1:0] data;
      int           pos;
   } word_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush[2];
   logic         in_valid[2];
   logic         out_ready[2];
   logic         in_rdy[2];
   logic         out_vld[2];
   logic [W-1:0] din[2];
   logic [W-1:0] dout[2];
`ifdef REGID_PIPE_OCC_EN
   logic [1:0]   occ0;
   logic [2:0]   occ1;
`endif

   int    checks   = 0;
   int    failures = 0;
   word_t mq[2][$];
   bit    acc[2];

   always #5 clk = ~clk;

   regid_pipe #(.WORD_SIZE(W), .DEPTH(D0)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush[0]),
      .in_valid  (in_valid[0]),
      .data_in   (din[0]),
      .in_ready  (in_rdy[0]),
      .out_valid (out_vld[0]),
      .data_out  (dout[0]),
      .out_ready (out_ready[0])
`ifdef REGID_PIPE_OCC_EN
      ,
      .occupancy (occ0)
`endif
   );

   regid_pipe #(.WORD_SIZE(W), .DEPTH(D1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush[1]),
      .in_valid  (in_valid[1]),
      .data_in   (din[1]),
      .in_ready  (in_rdy[1]),
      .out_valid (out_vld[1]),
      .data_out  (dout[1]),
      .out_ready (out_ready[1])
`ifdef REGID_PIPE_OCC_EN
      ,
      .occupancy (occ1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

`ifdef REGID_PIPE_OCC_EN
   function automatic logic [31:0] occ_of(input int k);
      return (k == 0) ? 32'(occ0) : 32'(occ1);
   endfunction
`endif

   // Reference: each word is tracked by its stage position. A word moves one
   // stage forward unless blocked by the word ahead of it; the input is ready
   // when any stage is free or the head leaves this cycle.
   task automatic model_step(input int k);
      int    dd;
      int    n;
      int    prev;
      bit    eir;
      bit    eov;
      word_t w;
      word_t nq[$];
      dd  = (k == 0) ? D0 : D1;
      n   = mq[k].size();
      eir = !flush[k] && (n < dd || out_ready[k]);
      eov = (n > 0) && (mq[k][0].pos == dd - 1);
      check($sformatf("in_ready[%0d]", k), 32'(in_rdy[k]), 32'(eir));
      check($sformatf("out_valid[%0d]", k), 32'(out_vld[k]), 32'(eov));
      if (eov) check($sformatf("data_out[%0d]", k), 32'(dout[k]), 32'(mq[k][0].data));
`ifdef REGID_PIPE_OCC_EN
      check($sformatf("occupancy[%0d]", k), occ_of(k), 32'(n));
`endif
      acc[k] = in_valid[k] && eir;
      if (flush[k]) begin
         mq[k].delete();
      end else begin
         prev = dd;
         for (int j = 0; j < n; j++) begin
            w = mq[k][j];
            if (!(j == 0 && eov && out_ready[k])) begin
               w.pos = (w.pos + 1 < prev - 1) ? w.pos + 1 : prev - 1;
               prev  = w.pos;
               nq.push_back(w);
            end
         end
         if (acc[k]) begin
            w.data = din[k];
            w.pos  = 0;
            nq.push_back(w);
         end
         mq[k] = nq;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic iv, input logic [W-1:0] d,
                        input logic ordy, input logic fl);
      in_valid[k]  = iv;
      din[k]       = d;
      out_ready[k] = ordy;
      flush[k]     = fl;
   endtask

   task automatic idle_all();
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      drive(1, 1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic reset_checks(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s out_valid[%0d]", tag, k), 32'(out_vld[k]), 32'd0);
         check($sformatf("%s data_out[%0d]", tag, k), 32'(dout[k]), 32'd0);
         check($sformatf("%s in_ready[%0d]", tag, k), 32'(in_rdy[k]), 32'd1);
`ifdef REGID_PIPE_OCC_EN
         check($sformatf("%s occupancy[%0d]", tag, k), occ_of(k), 32'd0);
`endif
      end
   endtask

   task automatic clear_models();
      mq[0].delete();
      mq[1].delete();
      acc[0] = 1'b0;
      acc[1] = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      idle_all();
      clear_models();
      repeat (2) @(posedge clk);
      #1;
      reset_checks("por");
      reset = 1'b1;

      // Streaming on DEPTH=2: 1,2,3 back-to-back.
      for (int i = 1; i <= 3; i++) begin
         drive(0, 1'b1, W'(i), 1'b1, 1'b0);
         cycle();
      end
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      repeat (3) cycle();

      // Backpressure on DEPTH=2: A, B then stalled, then drain.
      drive(0, 1'b1, 4'hA, 1'b0, 1'b0); cycle();
      drive(0, 1'b1, 4'hB, 1'b0, 1'b0); cycle();
      drive(0, 1'b0, '0, 1'b0, 1'b0);   cycle();
      check("bp_full in_ready", 32'(in_rdy[0]), 32'd0);
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      repeat (3) cycle();

      // Bubble collapse on DEPTH=4: 5, two idles, 6, 7, 8, then 9 stalls.
      drive(1, 1'b1, 4'h5, 1'b0, 1'b0); cycle();
      drive(1, 1'b0, '0, 1'b0, 1'b0);   repeat (2) cycle();
      drive(1, 1'b1, 4'h6, 1'b0, 1'b0); cycle();
      drive(1, 1'b1, 4'h7, 1'b0, 1'b0); cycle();
      drive(1, 1'b1, 4'h8, 1'b0, 1'b0); cycle();
      drive(1, 1'b1, 4'h9, 1'b0, 1'b0);
      repeat (2) cycle();
      check("bubble_full in_ready", 32'(in_rdy[1]), 32'd0);
      drive(1, 1'b1, 4'h9, 1'b1, 1'b0); cycle();
      drive(1, 1'b0, '0, 1'b1, 1'b0);
      repeat (6) cycle();

      // Full plus simultaneous push/pop on DEPTH=2.
      drive(0, 1'b1, 4'h1, 1'b0, 1'b0); cycle();
      drive(0, 1'b1, 4'h2, 1'b0, 1'b0); cycle();
      drive(0, 1'b0, '0, 1'b0, 1'b0);   cycle();
      drive(0, 1'b1, 4'h3, 1'b1, 1'b0);
      #1;
      check("push_pop in_ready", 32'(in_rdy[0]), 32'd1);
      check("push_pop data_out", 32'(dout[0]), 32'h1);
      cycle();
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      repeat (3) cycle();

      // Flush with two words held and a pending input 0xF.
      drive(0, 1'b1, 4'h4, 1'b0, 1'b0); cycle();
      drive(0, 1'b1, 4'h5, 1'b0, 1'b0); cycle();
      drive(0, 1'b1, 4'hF, 1'b0, 1'b1); cycle();
      drive(0, 1'b0, '0, 1'b1, 1'b0);
      #1;
      check("post_flush out_valid", 32'(out_vld[0]), 32'd0);
      repeat (4) cycle();

      // Asynchronous reset with words in flight.
      drive(0, 1'b1, 4'hC, 1'b0, 1'b0);
      drive(1, 1'b1, 4'hD, 1'b0, 1'b0);
      repeat (2) cycle();
      reset = 1'b0;
      idle_all();
      #1;
      reset_checks("midrst");
      clear_models();
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle();

      // Randomised traffic on both instances.
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!(in_valid[k] && !acc[k])) begin
               in_valid[k] = ($urandom_range(0, 3) != 0);
               din[k]      = W'($urandom);
            end
            out_ready[k] = ($urandom_range(0, 2) != 0);
            flush[k]     = ($urandom_range(0, 39) == 0);
         end
         cycle();
      end

      idle_all();
      repeat (6) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
